tile_write_scheduler: RTL and testbench

- Owns the single write port of the tile RAM (simple dual-port, 7-bit tile codes, 9-bit address) on the game clock domain.
- Round-robin arbitrates two write requesters, e.g. game logic and cursor/overlay logic.
- Contains a fill engine that writes one tile code to every on-screen tile, used for board clear and new game. It has priority over both requesters.
- Outputs drive the RAM's data, write-address and write-enable inputs directly.

---
 rtl/tile_write_scheduler.sv | 135 +++++++++++++
 tb/tb_tile_write_scheduler.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_write_scheduler.sv
// Single write-port owner for the tile RAM: round-robin arbitration between two
// requesters plus a full-screen fill engine that preempts both.
module tile_write_scheduler #(
    parameter int RAM_DATA_WIDTH = 7,
    parameter int RAM_ADDR_WIDTH = 9,
    parameter int TILE_COUNT     = 300
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [1:0]                req_i,
    input  logic [RAM_ADDR_WIDTH-1:0] addr0_i,
    input  logic [RAM_DATA_WIDTH-1:0] data0_i,
    input  logic [RAM_ADDR_WIDTH-1:0] addr1_i,
    input  logic [RAM_DATA_WIDTH-1:0] data1_i,
    output logic [1:0]                gnt_o,
    input  logic                      fill_start_i,
    input  logic [RAM_DATA_WIDTH-1:0] fill_data_i,
    output logic                      busy_o,
    output logic                      fill_done_o,
    output logic                      err_o,
    output logic                      we_o,
    output logic [RAM_ADDR_WIDTH-1:0] write_addr_o,
    output logic [RAM_DATA_WIDTH-1:0] data_o
);

    typedef enum logic {ARB, FILL} state_t;

    localparam logic [RAM_ADDR_WIDTH-1:0] LAST_TILE = RAM_ADDR_WIDTH'(TILE_COUNT - 1);
    localparam logic [RAM_ADDR_WIDTH-1:0] ONE       = RAM_ADDR_WIDTH'(1);

    state_t                    state;
    state_t                    state_next;
    logic                      last;
    logic [RAM_ADDR_WIDTH-1:0] cnt;
    logic [RAM_ADDR_WIDTH-1:0] cnt_inc;
    logic [1:0]                gnt;
    logic                      start;
    logic [RAM_ADDR_WIDTH-1:0] sel_addr;
    logic [RAM_DATA_WIDTH-1:0] sel_data;

    assign gnt_o   = gnt;
    assign cnt_inc = cnt + ONE;

    // Grant is combinational so a requester sees acceptance in the cycle it asks;
    // `last` records which requester won most recently (1 = requester 1).
    always_comb begin
        gnt        = 2'b00;
        start      = 1'b0;
        state_next = state;
        case (state)
            ARB: begin
                if (!rst_i) begin
                    if (fill_start_i) begin
                        start      = 1'b1;
                        state_next = FILL;
                    end else begin
                        case (req_i)
                            2'b01:   gnt = 2'b01;
                            2'b10:   gnt = 2'b10;
                            2'b11:   gnt = last ? 2'b01 : 2'b10;
                            default: gnt = 2'b00;
                        endcase
                    end
                end
            end
            FILL: begin
                if (cnt == LAST_TILE) state_next = ARB;
            end
            default: state_next = ARB;
        endcase
    end

    always_comb begin
        sel_addr = addr0_i;
        sel_data = data0_i;
        if (gnt[1]) begin
            sel_addr = addr1_i;
            sel_data = data1_i;
        end
    end

    // cnt tracks the fill address currently presented on write_addr_o.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= ARB;
            last         <= 1'b1;
            cnt          <= '0;
            we_o         <= 1'b0;
            busy_o       <= 1'b0;
            fill_done_o  <= 1'b0;
            err_o        <= 1'b0;
            write_addr_o <= '0;
            data_o       <= '0;
        end else begin
            state       <= state_next;
            we_o        <= 1'b0;
            err_o       <= 1'b0;
            fill_done_o <= 1'b0;
            case (state)
                ARB: begin
                    if (start) begin
                        busy_o       <= 1'b1;
                        we_o         <= 1'b1;
                        write_addr_o <= '0;
                        data_o       <= fill_data_i;
                        cnt          <= '0;
                        fill_done_o  <= (LAST_TILE == '0);
                    end else if (gnt != 2'b00) begin
                        last <= gnt[1];
                        if (sel_addr <= LAST_TILE) begin
                            we_o         <= 1'b1;
                            write_addr_o <= sel_addr;
                            data_o       <= sel_data;
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (cnt == LAST_TILE) begin
                        busy_o <= 1'b0;
                        cnt    <= '0;
                    end else begin
                        we_o         <= 1'b1;
                        write_addr_o <= cnt_inc;
                        cnt          <= cnt_inc;
                        fill_done_o  <= (cnt_inc == LAST_TILE);
                    end
                end
                default: busy_o <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_write_scheduler.sv
// Scoreboard bench for tile_write_scheduler: expected RAM writes are queued when
// stimulus is applied and matched against we_o/err_o as they appear.
module tb_tile_write_scheduler;

    localparam int DW = 7;
    localparam int AW = 9;
    localparam int TC = 300;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [1:0]    req_i;
    logic [AW-1:0] addr0_i, addr1_i;
    logic [DW-1:0] data0_i, data1_i;
    logic [1:0]    gnt_o;
    logic          fill_start_i;
    logic [DW-1:0] fill_data_i;
    logic          busy_o, fill_done_o, err_o, we_o;
    logic [AW-1:0] write_addr_o;
    logic [DW-1:0] data_o;

    always #5 clk = ~clk;

    tile_write_scheduler #(
        .RAM_DATA_WIDTH(DW),
        .RAM_ADDR_WIDTH(AW),
        .TILE_COUNT    (TC)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .addr0_i     (addr0_i),
        .data0_i     (data0_i),
        .addr1_i     (addr1_i),
        .data1_i     (data1_i),
        .gnt_o       (gnt_o),
        .fill_start_i(fill_start_i),
        .fill_data_i (fill_data_i),
        .busy_o      (busy_o),
        .fill_done_o (fill_done_o),
        .err_o       (err_o),
        .we_o        (we_o),
        .write_addr_o(write_addr_o),
        .data_o      (data_o)
    );

    typedef struct {
        logic          err;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          done;
    } exp_t;

    exp_t          q[$];
    int            checks = 0;
    int            errors = 0;
    logic [AW-1:0] last_a = '0;
    logic [DW-1:0] last_d = '0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (a >= AW'(TC)) begin
            q.push_back('{1'b1, last_a, last_d, 1'b0});
        end else begin
            q.push_back('{1'b0, a, d, 1'b0});
            last_a = a;
            last_d = d;
        end
    endtask

    // Applies one cycle of requests, checks the grant mid-cycle, queues the write.
    task automatic drive(input logic [1:0] r, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                         input logic [1:0] eg, input string tag);
        req_i   = r;
        addr0_i = a0;
        data0_i = d0;
        addr1_i = a1;
        data1_i = d1;
        @(negedge clk);
        chk(tag, gnt_o, eg);
        if (eg == 2'b01) push_wr(a0, d0);
        else if (eg == 2'b10) push_wr(a1, d1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i        = 1'b1;
        req_i        = 2'b11;
        fill_start_i = 1'b0;
        fill_data_i  = '0;
        addr0_i      = 9'd1;
        addr1_i      = 9'd2;
        data0_i      = 7'd1;
        data1_i      = 7'd2;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", gnt_o, 0);
        chk("rst_we", we_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", fill_done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_addr", write_addr_o, 0);
        chk("rst_data", data_o, 0);
        q.delete();
        last_a = '0;
        last_d = '0;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        req_i = 2'b00;
    endtask

    // Starts a fill with request pattern r held throughout; returns in cycle t+TC+1.
    task automatic run_fill(input logic [DW-1:0] code, input logic [1:0] r);
        fill_start_i = 1'b1;
        fill_data_i  = code;
        req_i        = r;
        @(negedge clk);
        chk("fill_start_gnt", gnt_o, 0);
        chk("fill_start_busy", busy_o, 0);
        for (int k = 0; k < TC; k++)
            q.push_back('{1'b0, AW'(k), code, (k == TC - 1)});
        last_a = AW'(TC - 1);
        last_d = code;
        @(posedge clk);
        #1;
        fill_data_i = 7'h11;
        for (int k = 0; k < TC; k++) begin
            fill_start_i = (k >= 10 && k < 20);
            @(negedge clk);
            chk("fill_busy", busy_o, 1);
            chk("fill_gnt", gnt_o, 0);
            @(posedge clk);
            #1;
        end
        fill_start_i = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst_i && (we_o || err_o || fill_done_o)) begin
            if (q.size() == 0) begin
                chk("spurious_we", we_o, 0);
                chk("spurious_err", err_o, 0);
                chk("spurious_done", fill_done_o, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("wr_we", we_o, !e.err);
                chk("wr_err", err_o, e.err);
                chk("wr_addr", write_addr_o, e.a);
                chk("wr_data", data_o, e.d);
                chk("wr_done", fill_done_o, e.done);
            end
        end
    end

    initial begin
        do_reset();

        // single request, 1-cycle latency, then idle
        drive(2'b01, 9'd5, 7'd3, 9'd0, 7'd0, 2'b01, "t1_gnt");
        drive(2'b00, 9'd5, 7'd3, 9'd0, 7'd0, 2'b00, "t1_idle_gnt");
        @(negedge clk);
        chk("t1_we_low", we_o, 0);
        @(posedge clk);
        #1;

        // both held: alternation starting with requester 0
        do_reset();
        for (int i = 0; i < 4; i++)
            drive(2'b11, AW'(10 + i), DW'(20 + i), AW'(100 + i), DW'(40 + i),
                  (i % 2 == 0) ? 2'b01 : 2'b10, "t2_gnt");
        drive(2'b00, 9'd0, 7'd0, 9'd0, 7'd0, 2'b00, "t2_idle_gnt");

        // fill with a later fill_data change that must be ignored
        run_fill(7'h2A, 2'b00);
        @(negedge clk);
        chk("t3_busy_after", busy_o, 0);
        chk("t3_we_after", we_o, 0);
        @(posedge clk);
        #1;

        // requester 0 served last, both wait through a fill; 1 must win first
        drive(2'b01, 9'd7, 7'd8, 9'd0, 7'd0, 2'b01, "t4_pre_gnt");
        run_fill(7'h55, 2'b11);
        drive(2'b11, 9'd30, 7'd31, 9'd32, 7'd33, 2'b10, "t4_first_gnt");
        drive(2'b11, 9'd34, 7'd35, 9'd36, 7'd37, 2'b01, "t4_second_gnt");
        drive(2'b00, 9'd0, 7'd0, 9'd0, 7'd0, 2'b00, "t4_idle_gnt");

        // fill start beats a simultaneous request
        addr0_i = 9'd40;
        data0_i = 7'd9;
        run_fill(7'h07, 2'b01);
        drive(2'b01, 9'd40, 7'd9, 9'd0, 7'd0, 2'b01, "t5_gnt");
        drive(2'b00, 9'd0, 7'd0, 9'd0, 7'd0, 2'b00, "t5_idle_gnt");

        // out-of-range address: granted, dropped, err pulse, outputs hold
        drive(2'b10, 9'd0, 7'd0, 9'd300, 7'd5, 2'b10, "t6_gnt");
        drive(2'b00, 9'd0, 7'd0, 9'd300, 7'd5, 2'b00, "t6_idle_gnt");
        @(negedge clk);
        chk("t6_err_once", err_o, 0);
        @(posedge clk);
        #1;
        drive(2'b10, 9'd0, 7'd0, 9'd299, 7'd6, 2'b10, "t6_edge_gnt");
        drive(2'b00, 9'd0, 7'd0, 9'd0, 7'd0, 2'b00, "t6_edge_idle");

        // reset while address 150 is being written
        fill_start_i = 1'b1;
        fill_data_i  = 7'h3C;
        req_i        = 2'b00;
        @(negedge clk);
        for (int k = 0; k < TC; k++)
            q.push_back('{1'b0, AW'(k), 7'h3C, (k == TC - 1)});
        @(posedge clk);
        #1;
        fill_start_i = 1'b0;
        for (int k = 0; k <= 150; k++) begin
            @(negedge clk);
            if (k < 150) begin
                @(posedge clk);
                #1;
            end
        end
        #1;
        rst_i = 1'b1;
        #1;
        chk("t7_we_abort", we_o, 0);
        chk("t7_busy_abort", busy_o, 0);
        chk("t7_done_abort", fill_done_o, 0);
        q.delete();
        last_a = '0;
        last_d = '0;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t7_busy_post", busy_o, 0);
            chk("t7_done_post", fill_done_o, 0);
            @(posedge clk);
            #1;
        end
        drive(2'b11, 9'd1, 7'd2, 9'd3, 7'd4, 2'b01, "t7_ptr_gnt");
        drive(2'b00, 9'd0, 7'd0, 9'd0, 7'd0, 2'b00, "t7_idle_gnt");

        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
